// File: rtl/encoder_scan_ctrl.sv
// Round-robin encoder edge counter: one gated rising-edge counter is time-shared
// across NCH synchronized inputs, and each result is delivered on a valid/ready port.
module encoder_scan_ctrl #(
    parameter int NCH    = 4,
    parameter int CW     = 8,
    parameter int GW     = 8,
    parameter int SETTLE = 2,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           OUT_CLK,
    input  logic           RST,
    input  logic           en,
    input  logic [GW-1:0]  gate_len,
    input  logic [NCH-1:0] A,
    input  logic           res_ready,
    output logic           res_valid,
    output logic [CHW-1:0] res_ch,
    output logic [CW-1:0]  res_count,
    output logic           res_ovf,
    output logic           busy,
    output logic [CHW-1:0] ch_sel
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_HOLD
    } state_t;

    state_t         state_q;
    logic [NCH-1:0] sync1_q, sync2_q, sync3_q;
    logic [CHW-1:0] chSel_q;
    logic [GW-1:0]  gl_q;
    logic [GW-1:0]  gateCnt_q;
    logic [SW-1:0]  settleCnt_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic           resValid_q;
    logic [CHW-1:0] resCh_q;
    logic [CW-1:0]  resCount_q;
    logic           resOvf_q;

    logic [NCH-1:0] edgeVec;
    logic           edgeSel;
    logic [GW-1:0]  glEff;
    logic [CHW-1:0] chNext;

    assign edgeVec = sync2_q & ~sync3_q;
    assign edgeSel = edgeVec[chSel_q];
    assign glEff   = (gate_len == '0) ? GW'(1) : gate_len;
    assign chNext  = (chSel_q == CHW'(NCH - 1)) ? '0 : chSel_q + 1'b1;

    // Saturating count: once at all-ones further edges only raise the overflow flag.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (edgeSel) begin
            if (cnt_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge OUT_CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            chSel_q     <= '0;
            gl_q        <= '0;
            gateCnt_q   <= '0;
            settleCnt_q <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            resValid_q  <= 1'b0;
            resCh_q     <= '0;
            resCount_q  <= '0;
            resOvf_q    <= 1'b0;
        end else begin
            sync1_q <= A;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q     <= ST_SETTLE;
                        settleCnt_q <= '0;
                        gl_q        <= glEff;
                    end
                end
                ST_SETTLE: begin
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                    if (settleCnt_q == SW'(SETTLE - 1)) begin
                        state_q   <= ST_GATE;
                        gateCnt_q <= '0;
                    end else begin
                        settleCnt_q <= settleCnt_q + 1'b1;
                    end
                end
                ST_GATE: begin
                    cnt_q <= cnt_d;
                    ovf_q <= ovf_d;
                    // The final gate cycle's edge is folded straight into the result.
                    if (gateCnt_q == gl_q - GW'(1)) begin
                        state_q    <= ST_HOLD;
                        resValid_q <= 1'b1;
                        resCount_q <= cnt_d;
                        resOvf_q   <= ovf_d;
                        resCh_q    <= chSel_q;
                    end else begin
                        gateCnt_q <= gateCnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        resValid_q <= 1'b0;
                        chSel_q    <= chNext;
                        if (en) begin
                            state_q     <= ST_SETTLE;
                            settleCnt_q <= '0;
                            gl_q        <= glEff;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign res_valid = resValid_q;
    assign res_ch    = resCh_q;
    assign res_count = resCount_q;
    assign res_ovf   = resOvf_q;
    assign busy      = (state_q != ST_IDLE);
    assign ch_sel    = chSel_q;

endmodule

// File: tb/tb_encoder_scan_ctrl.sv
// Scoreboard bench for encoder_scan_ctrl: each measurement window pushes its expected
// result, and a negedge monitor pops and compares on every valid/ready transfer.
module tb_encoder_scan_ctrl;

    localparam int NCH    = 4;
    localparam int CW     = 4;
    localparam int GW     = 8;
    localparam int SETTLE = 2;
    localparam int MAXC   = (1 << CW) - 1;

    logic          OUT_CLK;
    logic          RST;
    logic          en;
    logic [GW-1:0] gate_len;
    logic [NCH-1:0] A;
    logic          res_ready;
    logic          res_valid;
    logic [1:0]    res_ch;
    logic [CW-1:0] res_count;
    logic          res_ovf;
    logic          busy;
    logic [1:0]    ch_sel;

    typedef struct packed {
        logic [1:0]    ch;
        logic [CW-1:0] count;
        logic          ovf;
    } res_t;

    res_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   e0Cyc  = 0;

    encoder_scan_ctrl #(
        .NCH(NCH), .CW(CW), .GW(GW), .SETTLE(SETTLE)
    ) dut (
        .OUT_CLK(OUT_CLK),
        .RST(RST),
        .en(en),
        .gate_len(gate_len),
        .A(A),
        .res_ready(res_ready),
        .res_valid(res_valid),
        .res_ch(res_ch),
        .res_count(res_count),
        .res_ovf(res_ovf),
        .busy(busy),
        .ch_sel(ch_sel)
    );

    initial OUT_CLK = 1'b0;
    always #5 OUT_CLK = ~OUT_CLK;

    always @(posedge OUT_CLK) cyc <= cyc + 1;

    // Every transfer must match the oldest outstanding expectation.
    always @(negedge OUT_CLK) begin
        if (RST === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected got ch=%0d count=%0d ovf=%0d with nothing expected",
                         res_ch, res_count, res_ovf);
            end else begin
                res_t exp;
                exp = expQ.pop_front();
                if ({res_ch, res_count, res_ovf} !== exp) begin
                    errors++;
                    $display("[TB] FAIL sb_result got ch=%0d count=%0d ovf=%0d expected ch=%0d count=%0d ovf=%0d",
                             res_ch, res_count, res_ovf, exp.ch, exp.count, exp.ovf);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    function automatic res_t model(input int ch, input int n);
        res_t r;
        r.ch    = ch[1:0];
        r.count = (n > MAXC) ? CW'(MAXC) : CW'(n);
        r.ovf   = (n > MAXC);
        return r;
    endfunction

    task automatic do_reset();
        @(posedge OUT_CLK);
        #1;
        RST = 1'b1;
        en = 1'b0;
        A = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge OUT_CLK);
        #1;
        RST = 1'b0;
    endtask

    // The next posedge must move the FSM into SETTLE; rising edges on A[ch] land inside the gate.
    task automatic window(input int ch, input int n, input int h, input bit push);
        if (push) expQ.push_back(model(ch, n));
        @(posedge OUT_CLK);
        #1;
        e0Cyc = cyc;
        A = '0;
        for (int c = 2; c <= 2 + 2 * h * n; c++) begin
            @(posedge OUT_CLK);
            #1;
            if ((c - 2) < 2 * h * n && ((c - 2) % (2 * h)) < h) A[ch] = 1'b1;
            else A = '0;
        end
    endtask

    task automatic wait_valid(input string tag, output int at);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge OUT_CLK);
            if (res_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        at = cyc;
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s_valid_timeout got res_valid=%b expected 1 within 300 cycles", tag, res_valid);
        end
    endtask

    task automatic test_reset();
        int at;
        bit sawValid;
        @(negedge OUT_CLK);
        checks++;
        if ({res_valid, res_ch, res_count, res_ovf, busy, ch_sel} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_initial got %b expected all zero",
                     {res_valid, res_ch, res_count, res_ovf, busy, ch_sel});
        end
        @(posedge OUT_CLK);
        #1;
        RST = 1'b0;
        gate_len = 8'd30;
        res_ready = 1'b1;
        en = 1'b1;
        window(0, 2, 1, 1'b1);
        wait_valid("rst_ch0", at);
        window(1, 4, 1, 1'b1);
        wait_valid("rst_ch1", at);
        window(2, 6, 1, 1'b0);
        repeat (4) @(negedge OUT_CLK);
        checks++;
        if ({busy, ch_sel, res_valid} !== {1'b1, 2'd2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rst_midgate_state got busy=%b ch_sel=%0d valid=%b expected busy=1 ch_sel=2 valid=0",
                     busy, ch_sel, res_valid);
        end
        @(posedge OUT_CLK);
        #1;
        RST = 1'b1;
        en = 1'b0;
        #2;
        checks++;
        if ({res_valid, res_ch, res_count, res_ovf, busy, ch_sel} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_midgate got %b expected all zero",
                     {res_valid, res_ch, res_count, res_ovf, busy, ch_sel});
        end
        repeat (2) @(posedge OUT_CLK);
        #1;
        RST = 1'b0;
        sawValid = 1'b0;
        repeat (40) begin
            @(negedge OUT_CLK);
            if (res_valid !== 1'b0 || busy !== 1'b0) sawValid = 1'b1;
        end
        checks++;
        if (sawValid) begin
            errors++;
            $display("[TB] FAIL reset_quiet got activity=1 expected 0 after reset with en=0");
        end
    endtask

    task automatic test_basic();
        int at;
        do_reset();
        gate_len = 8'd20;
        res_ready = 1'b1;
        en = 1'b1;
        window(0, 5, 2, 1'b1);
        en = 1'b0;
        wait_valid("basic", at);
        checks++;
        if (at - e0Cyc != SETTLE + 20) begin
            errors++;
            $display("[TB] FAIL basic_latency got %0d expected %0d", at - e0Cyc, SETTLE + 20);
        end
        repeat (3) @(negedge OUT_CLK);
        checks++;
        if ({busy, ch_sel} !== {1'b0, 2'd1}) begin
            errors++;
            $display("[TB] FAIL basic_idle got busy=%b ch_sel=%0d expected busy=0 ch_sel=1", busy, ch_sel);
        end
    endtask

    task automatic test_round_robin();
        int at;
        int nrr [5];
        nrr = '{3, 7, 0, 12, 2};
        do_reset();
        gate_len = 8'd30;
        res_ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            window(i % NCH, nrr[i], 1, 1'b1);
            wait_valid("rr", at);
        end
        en = 1'b0;
        repeat (3) @(negedge OUT_CLK);
        checks++;
        if ({busy, ch_sel} !== {1'b0, 2'd1}) begin
            errors++;
            $display("[TB] FAIL rr_final got busy=%b ch_sel=%0d expected busy=0 ch_sel=1", busy, ch_sel);
        end
    endtask

    task automatic test_backpressure();
        int at;
        do_reset();
        gate_len = 8'd20;
        res_ready = 1'b0;
        en = 1'b1;
        window(0, 4, 2, 1'b1);
        wait_valid("bp", at);
        for (int b = 0; b < 10; b++) begin
            @(posedge OUT_CLK);
            #1;
            A = (b < 7 && (b % 2) == 0) ? 4'hF : 4'h0;
            @(negedge OUT_CLK);
            checks++;
            if ({res_valid, res_ch, res_count, res_ovf, ch_sel} !== {1'b1, 2'd0, 4'd4, 1'b0, 2'd0}) begin
                errors++;
                $display("[TB] FAIL bp_hold got valid=%b ch=%0d count=%0d ovf=%b ch_sel=%0d expected valid=1 ch=0 count=4 ovf=0 ch_sel=0",
                         res_valid, res_ch, res_count, res_ovf, ch_sel);
            end
        end
        @(posedge OUT_CLK);
        #1;
        A = '0;
        res_ready = 1'b1;
        window(1, 3, 2, 1'b1);
        wait_valid("bp_next", at);
        en = 1'b0;
        repeat (3) @(negedge OUT_CLK);
        checks++;
        if ({busy, ch_sel} !== {1'b0, 2'd2}) begin
            errors++;
            $display("[TB] FAIL bp_final got busy=%b ch_sel=%0d expected busy=0 ch_sel=2", busy, ch_sel);
        end
    endtask

    task automatic test_saturation();
        int at;
        int nsat [4];
        nsat = '{20, 2, 15, 16};
        do_reset();
        gate_len = 8'd60;
        res_ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            window(i, nsat[i], 1, 1'b1);
            wait_valid("sat", at);
        end
        en = 1'b0;
        repeat (3) @(negedge OUT_CLK);
        checks++;
        if ({busy, ch_sel} !== {1'b0, 2'd0}) begin
            errors++;
            $display("[TB] FAIL sat_wrap got busy=%b ch_sel=%0d expected busy=0 ch_sel=0", busy, ch_sel);
        end
    endtask

    task automatic test_corner();
        int at;
        bit sawValid;
        do_reset();
        gate_len = 8'd0;
        res_ready = 1'b1;
        en = 1'b1;
        window(0, 0, 1, 1'b1);
        en = 1'b0;
        wait_valid("gl0", at);
        checks++;
        if (at - e0Cyc != SETTLE + 1) begin
            errors++;
            $display("[TB] FAIL gl0_latency got %0d expected %0d", at - e0Cyc, SETTLE + 1);
        end

        do_reset();
        gate_len = 8'd20;
        res_ready = 1'b1;
        en = 1'b1;
        fork
            window(0, 5, 2, 1'b1);
            begin
                repeat (8) @(posedge OUT_CLK);
                #1;
                gate_len = 8'd5;
                en = 1'b0;
            end
        join
        wait_valid("glchg", at);
        checks++;
        if (at - e0Cyc != SETTLE + 20) begin
            errors++;
            $display("[TB] FAIL glchg_latency got %0d expected %0d", at - e0Cyc, SETTLE + 20);
        end
        repeat (3) @(negedge OUT_CLK);
        checks++;
        if ({busy, ch_sel} !== {1'b0, 2'd1}) begin
            errors++;
            $display("[TB] FAIL endrop_idle got busy=%b ch_sel=%0d expected busy=0 ch_sel=1", busy, ch_sel);
        end
        sawValid = 1'b0;
        repeat (30) begin
            @(negedge OUT_CLK);
            if (res_valid !== 1'b0) sawValid = 1'b1;
        end
        checks++;
        if (sawValid) begin
            errors++;
            $display("[TB] FAIL endrop_quiet got res_valid=1 expected 0 after en dropped");
        end
    endtask

    initial begin
        RST = 1'b1;
        en = 1'b0;
        gate_len = '0;
        A = '0;
        res_ready = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_corner();
        repeat (5) @(negedge OUT_CLK);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_leftover got %0d pending expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_scan_ctrl.md
Name: encoder_scan_ctrl

Overview:
- Round-robin measurement scheduler that time-shares one gated rising-edge counter across NCH encoder inputs.
- Per channel: selects the input, settles, counts synchronized rising edges over a programmable gate window, then presents the result on a valid/ready port.
- Sits in the slow OUT_CLK domain, downstream of the clock divider, feeding speed/position logic.

Parameters:
- NCH, 4, number of encoder channels (2..8).
- CW, 8, result count width.
- GW, 8, gate-length width.
- SETTLE, 2, settle cycles after channel switch (>=1).

Ports:
- OUT_CLK  in  1  measurement clock, all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- en  in  1  scan enable, level.
- gate_len  in  GW  gate window length in OUT_CLK cycles; 0 treated as 1.
- A  in  NCH  raw encoder inputs, asynchronous to OUT_CLK.
- res_ready  in  1  consumer accepts the result.
- res_valid  out  1  result available.
- res_ch  out  CHW=clog2(NCH)  channel of the result.
- res_count  out  CW  edge count of the result.
- res_ovf  out  1  count saturated during the gate.
- busy  out  1  state != IDLE.
- ch_sel  out  CHW  channel currently scheduled.

Behaviour:
- Reset (async assert, sync-release use): state IDLE; ch_sel=0; res_valid=0; res_ch=0; res_count=0; res_ovf=0; busy=0; all synchronizer, edge and counter flops 0.
- Input conditioning:
  - Every A bit passes through a 2-flop synchronizer plus a delay flop, running continuously.
  - edge[i] = s2[i] & ~s3[i].
  - Only edge[ch_sel] is used.
- FSM states: IDLE, SETTLE, GATE, HOLD.
- IDLE:
  - en sampled 1 -> SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - Lasts exactly SETTLE cycles.
  - Clears the working counter and ovf.
  - On entry, latches gl = (gate_len==0) ? 1 : gate_len.
  - Exit -> GATE.
- GATE:
  - Lasts exactly gl cycles.
  - Each cycle with edge[ch_sel]=1 increments the counter.
  - Saturating: at 2^CW-1 the count holds; an edge at max sets ovf.
  - gate_len changes during GATE have no effect.
  - Exit -> HOLD, loading res_count, res_ovf and res_ch=ch_sel.
- HOLD:
  - res_valid=1; res_* held stable.
  - Transfer occurs on the clock edge where res_valid and res_ready are both 1.
  - On transfer: res_valid->0 and ch_sel -> (ch_sel==NCH-1) ? 0 : ch_sel+1.
  - Next state: SETTLE if en=1 in the transfer cycle, else IDLE.
  - No counting in HOLD; edges during backpressure are dropped.
- Latency: en sampled high in IDLE at cycle t -> res_valid first high at t+1+SETTLE+gl.
- res_ready while res_valid=0: ignored.
- en deasserted in SETTLE or GATE: the current measurement completes and is delivered; after transfer, go to IDLE.
- RST mid-operation: immediate return to reset values; the partial measurement is discarded.

Test Plan:
1. Reset: assert RST mid-GATE with count=6 and ch_sel=2 -> all outputs 0, busy=0, ch_sel=0, no res_valid afterwards while en=0.
2. Basic count: NCH=4, SETTLE=2, gate_len=20, res_ready=1, en rises at t, A[0] gives 5 rising edges spaced 4 cycles inside the window -> res_valid at t+23, res_ch=0, res_count=5, res_ovf=0.
3. Round-robin: en held high, res_ready=1, channels 0..3 given 3, 7, 0 and 12 edges per window -> results in order (0,3), (1,7), (2,0), (3,12), then ch_sel wraps to 0 and the next result has res_ch=0.
4. Backpressure: res_ready=0 for 10 cycles in HOLD with edges on A -> res_valid stays 1, res_* unchanged, ch_sel unchanged; after ready, the next channel's count excludes those edges.
5. Saturation: CW=4, gate_len=60, 20 edges -> res_count=15, res_ovf=1; the next window with 2 edges -> res_count=2, res_ovf=0.
6. Corner config: gate_len=0 -> GATE lasts 1 cycle; change gate_len 20->5 mid-GATE -> window stays 20; drop en mid-GATE -> one result delivered, then IDLE, busy=0.
